// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer scheduler: index width and FSM state encoding.
package neuron_pkg;

    localparam int IDX_W = 16;
    localparam logic [IDX_W-1:0] IDX_ZERO = 16'd0;
    localparam logic [IDX_W-1:0] IDX_ONE  = 16'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/neuron_layer_scheduler_idx_counter.sv
// Index bookkeeping for the layer: input counter k, weight base (+N per neuron)
// and neuron counter, each with a terminal flag where the scheduler needs one.
module idx_counter
    import neuron_pkg::*;
#(
    parameter int N = 10,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             layer_clr,
    input  logic             k_clr,
    input  logic             k_inc,
    input  logic             neuron_inc,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] neuron,
    output logic             k_last,
    output logic             neuron_last
);

    logic [IDX_W-1:0] k_r;
    logic [IDX_W-1:0] base_r;
    logic [IDX_W-1:0] neuron_r;

    // Input index within the current neuron.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r <= IDX_ZERO;
        end else if (k_clr) begin
            k_r <= IDX_ZERO;
        end else if (k_inc) begin
            k_r <= k_r + IDX_ONE;
        end else begin
            k_r <= k_r;
        end
    end

    // Running weight base replaces neuron*N so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r   <= IDX_ZERO;
            neuron_r <= IDX_ZERO;
        end else if (layer_clr) begin
            base_r   <= IDX_ZERO;
            neuron_r <= IDX_ZERO;
        end else if (neuron_inc) begin
            base_r   <= base_r + IDX_W'(N);
            neuron_r <= neuron_r + IDX_ONE;
        end else begin
            base_r   <= base_r;
            neuron_r <= neuron_r;
        end
    end

    assign k           = k_r;
    assign base        = base_r;
    assign neuron      = neuron_r;
    assign k_last      = (k_r == IDX_W'(N - 1));
    assign neuron_last = (neuron_r == IDX_W'(M - 1));

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one shared MAC datapath across the M neurons of a layer.
// All outputs come straight from flops loaded with the values for the next state.
module neuron_layer_scheduler
    import neuron_pkg::*;
#(
    parameter int N   = 10,
    parameter int M   = 4,
    parameter int LAT = 1,
    parameter int OW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             acc_clr,
    output logic             ld,
    output logic [IDX_W-1:0] in_idx,
    output logic [IDX_W-1:0] w_idx,
    input  logic [OW-1:0]    acc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic [IDX_W-1:0] out_neuron,
    output logic             done
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] drain_r;
    logic             layer_clr_s;
    logic             k_clr_s;
    logic             k_inc_s;
    logic             neuron_inc_s;
    logic             capture_s;
    logic             hs_s;
    logic             drain_last_s;
    logic [IDX_W-1:0] k_s;
    logic [IDX_W-1:0] base_s;
    logic [IDX_W-1:0] neuron_s;
    logic             k_last_s;
    logic             neuron_last_s;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [IDX_W-1:0] w_nxt_s;
    logic [IDX_W-1:0] neuron_nxt_s;
    logic [OW-1:0]    data_nxt_s;

    logic             busy_r;
    logic             acc_clr_r;
    logic             ld_r;
    logic [IDX_W-1:0] in_idx_r;
    logic [IDX_W-1:0] w_idx_r;
    logic             out_valid_r;
    logic [OW-1:0]    out_data_r;
    logic [IDX_W-1:0] out_neuron_r;
    logic             done_r;

    idx_counter #(.N(N), .M(M)) u_idx (
        .clk         (clk),
        .rst         (rst),
        .layer_clr   (layer_clr_s),
        .k_clr       (k_clr_s),
        .k_inc       (k_inc_s),
        .neuron_inc  (neuron_inc_s),
        .k           (k_s),
        .base        (base_s),
        .neuron      (neuron_s),
        .k_last      (k_last_s),
        .neuron_last (neuron_last_s)
    );

    assign hs_s         = out_valid_r & out_ready;
    assign drain_last_s = (drain_r == IDX_W'(LAT - 1));

    // Next-state and counter control.
    always_comb begin
        state_nxt_s  = state_r;
        layer_clr_s  = 1'b0;
        k_clr_s      = 1'b0;
        k_inc_s      = 1'b0;
        neuron_inc_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_CLEAR;
                    layer_clr_s = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_nxt_s = S_ACC;
                k_clr_s     = 1'b1;
            end
            S_ACC: begin
                if (k_last_s) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    k_inc_s = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_last_s) begin
                    state_nxt_s = S_EMIT;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_EMIT: begin
                if (hs_s && neuron_last_s) begin
                    state_nxt_s = S_DONE;
                end else if (hs_s) begin
                    state_nxt_s  = S_CLEAR;
                    neuron_inc_s = 1'b1;
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Values the output flops take on entry to / while in the next state.
    always_comb begin
        idx_nxt_s    = IDX_ZERO;
        w_nxt_s      = IDX_ZERO;
        neuron_nxt_s = IDX_ZERO;
        data_nxt_s   = out_data_r;
        if (state_nxt_s == S_ACC) begin
            idx_nxt_s = (state_r == S_ACC) ? (k_s + IDX_ONE) : IDX_ZERO;
            w_nxt_s   = base_s + idx_nxt_s;
        end else begin
            idx_nxt_s = IDX_ZERO;
            w_nxt_s   = IDX_ZERO;
        end
        if (capture_s) begin
            data_nxt_s   = acc_in;
            neuron_nxt_s = neuron_s;
        end else if (state_nxt_s == S_EMIT) begin
            neuron_nxt_s = out_neuron_r;
        end else begin
            neuron_nxt_s = IDX_ZERO;
        end
    end

    // State and drain-latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            drain_r <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            drain_r <= (state_r == S_DRAIN) ? (drain_r + IDX_ONE) : IDX_ZERO;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= 1'b0;
            acc_clr_r    <= 1'b0;
            ld_r         <= 1'b0;
            in_idx_r     <= IDX_ZERO;
            w_idx_r      <= IDX_ZERO;
            out_valid_r  <= 1'b0;
            out_data_r   <= {OW{1'b0}};
            out_neuron_r <= IDX_ZERO;
            done_r       <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s != S_IDLE);
            acc_clr_r    <= (state_nxt_s == S_CLEAR);
            ld_r         <= (state_nxt_s == S_ACC);
            in_idx_r     <= idx_nxt_s;
            w_idx_r      <= w_nxt_s;
            out_valid_r  <= (state_nxt_s == S_EMIT);
            out_data_r   <= data_nxt_s;
            out_neuron_r <= neuron_nxt_s;
            done_r       <= (state_nxt_s == S_DONE);
        end
    end

    assign busy       = busy_r;
    assign acc_clr    = acc_clr_r;
    assign ld         = ld_r;
    assign in_idx     = in_idx_r;
    assign w_idx      = w_idx_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_neuron = out_neuron_r;
    assign done       = done_r;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Bench for neuron_layer_scheduler: default layer (10x4, LAT 1) plus a 1x1, LAT 3 instance,
// each driven by a small MAC datapath model; results checked through scoreboard queues.
module tb_neuron_layer_scheduler;

    localparam int OW = 16;

    typedef struct packed {
        logic [15:0]   neuron;
        logic [OW-1:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int n_cmp = 0;
    int n_bad = 0;
    res_t exp_q[$];
    res_t exp_b[$];

    logic          a_start, a_busy, a_acc_clr, a_ld, a_out_valid, a_out_ready, a_done;
    logic [15:0]   a_in_idx, a_w_idx, a_out_neuron;
    logic [OW-1:0] a_acc_in, a_out_data, acc_a;
    logic          b_start, b_busy, b_acc_clr, b_ld, b_out_valid, b_out_ready, b_done;
    logic [15:0]   b_in_idx, b_w_idx, b_out_neuron;
    logic [OW-1:0] b_acc_in, b_out_data, acc_b, b_d1, b_d2;

    neuron_layer_scheduler #(.N(10), .M(4), .LAT(1), .OW(OW)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .acc_clr(a_acc_clr), .ld(a_ld),
        .in_idx(a_in_idx), .w_idx(a_w_idx), .acc_in(a_acc_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_neuron(a_out_neuron), .done(a_done)
    );

    neuron_layer_scheduler #(.N(1), .M(1), .LAT(3), .OW(OW)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .acc_clr(b_acc_clr), .ld(b_ld),
        .in_idx(b_in_idx), .w_idx(b_w_idx), .acc_in(b_acc_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_neuron(b_out_neuron), .done(b_done)
    );

    // Datapath A: inputs all 1, weight = w_idx, latency 1.
    always @(posedge clk or posedge rst) begin
        if (rst) acc_a <= '0;
        else if (a_acc_clr) acc_a <= '0;
        else if (a_ld) acc_a <= acc_a + a_w_idx;
    end
    assign a_acc_in = acc_a;

    // Datapath B: input 7, weight = w_idx + 3, two extra pipeline stages (latency 3).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_b <= '0; b_d1 <= '0; b_d2 <= '0;
        end else begin
            if (b_acc_clr) acc_b <= '0;
            else if (b_ld) acc_b <= acc_b + 16'd7 * (b_w_idx + 16'd3);
            b_d1 <= acc_b;
            b_d2 <= b_d1;
        end
    end
    assign b_acc_in = b_d2;

    // Scoreboard for instance A: pop on every accepted result.
    always @(negedge clk) begin
        res_t e;
        #1;
        if (!rst && a_out_valid && a_out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: got neuron %0d data %0d, required no result", a_out_neuron, a_out_data);
            end else begin
                e = exp_q.pop_front();
                if (a_out_neuron !== e.neuron || a_out_data !== e.data) begin
                    n_bad++;
                    $display("FAIL sb_result: got neuron %0d data %0d, required neuron %0d data %0d",
                             a_out_neuron, a_out_data, e.neuron, e.data);
                end
            end
        end
    end

    task automatic push_layer_a();
        for (int n = 0; n < 4; n++) exp_q.push_back('{16'(n), 16'(100 * n + 45)});
    endtask

    task automatic test_reset();
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_busy, a_acc_clr, a_ld, a_out_valid, a_done} !== 5'b0 || a_in_idx !== 16'd0 ||
            a_w_idx !== 16'd0 || a_out_data !== 16'd0 || a_out_neuron !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_a: got busy %b ld %b w_idx %0d, required all zero", a_busy, a_ld, a_w_idx);
        end
        n_cmp++;
        if ({b_busy, b_acc_clr, b_ld, b_out_valid, b_done} !== 5'b0 || b_out_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_b: got busy %b ld %b, required all zero", b_busy, b_ld);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_start: got busy %b, required 0", a_busy);
        end
    endtask

    task automatic test_basic();
        int s, c, nld, done_c, exp_w;
        push_layer_a();
        @(negedge clk); a_start = 1'b1; s = ecnt;
        nld = 0; done_c = -1; exp_w = 0;
        for (int i = 0; i < 120 && done_c < 0; i++) begin
            @(negedge clk); a_start = 1'b0; c = ecnt - s;
            if (a_ld) begin
                n_cmp++;
                if (a_w_idx !== 16'(exp_w) || a_in_idx !== 16'(exp_w % 10) || a_acc_clr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL basic_ld: cycle %0d got w_idx %0d in_idx %0d clr %b, required w_idx %0d in_idx %0d clr 0",
                             c, a_w_idx, a_in_idx, a_acc_clr, exp_w, exp_w % 10);
                end
                exp_w++; nld++;
            end
            if (a_done) done_c = c;
        end
        n_cmp++;
        if (nld != 40 || done_c != 53 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL basic_totals: got ld %0d done cycle %0d pending %0d, required 40 53 0", nld, done_c, exp_q.size());
        end
        @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_drop: got busy %b done %b, required 0 0", a_busy, a_done);
        end
    endtask

    task automatic test_stall();
        int s, c, c_s, done_c;
        push_layer_a();
        @(negedge clk); a_start = 1'b1; s = ecnt;
        c_s = -1; done_c = -1;
        for (int i = 0; i < 120 && done_c < 0; i++) begin
            @(negedge clk); a_start = 1'b0; c = ecnt - s;
            if (c_s < 0) begin
                if (a_out_valid && a_out_neuron == 16'd1) begin
                    c_s = c; a_out_ready = 1'b0;
                end
            end else if (c <= c_s + 5) begin
                n_cmp++;
                if (a_out_valid !== 1'b1 || a_out_data !== 16'd145 || a_out_neuron !== 16'd1 ||
                    a_ld !== 1'b0 || a_acc_clr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_hold: cycle %0d got valid %b data %0d neuron %0d ld %b clr %b, required 1 145 1 0 0",
                             c, a_out_valid, a_out_data, a_out_neuron, a_ld, a_acc_clr);
                end
                if (c == c_s + 5) a_out_ready = 1'b1;
            end
            if (a_done) done_c = c;
        end
        a_out_ready = 1'b1;
        n_cmp++;
        if (c_s != 26 || done_c != 58 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_timing: got emit %0d done %0d pending %0d, required 26 58 0", c_s, done_c, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int s, c, done_c, stray;
        push_layer_a();
        @(negedge clk); a_start = 1'b1; s = ecnt;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); a_start = 1'b0;
        end
        c = ecnt - s;
        n_cmp++;
        if (c != 30 || a_ld !== 1'b1 || a_w_idx !== 16'd22 || a_in_idx !== 16'd2) begin
            n_bad++;
            $display("FAIL mid_acc: cycle %0d got ld %b w_idx %0d in_idx %0d, required 1 22 2", c, a_ld, a_w_idx, a_in_idx);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_busy, a_acc_clr, a_ld, a_out_valid, a_done} !== 5'b0 || a_w_idx !== 16'd0 || a_in_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy %b ld %b w_idx %0d, required all zero", a_busy, a_ld, a_w_idx);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_ld || a_done || a_busy || a_out_valid) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: got %0d active cycles after reset, required 0", stray);
        end
        push_layer_a();
        @(negedge clk); a_start = 1'b1; s = ecnt; done_c = -1;
        for (int i = 0; i < 120 && done_c < 0; i++) begin
            @(negedge clk); a_start = 1'b0; c = ecnt - s;
            if (c == 1) begin
                n_cmp++;
                if (a_acc_clr !== 1'b1 || a_ld !== 1'b0) begin
                    n_bad++;
                    $display("FAIL restart_clr: got clr %b ld %b, required 1 0", a_acc_clr, a_ld);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (a_ld !== 1'b1 || a_w_idx !== 16'd0 || a_in_idx !== 16'd0) begin
                    n_bad++;
                    $display("FAIL restart_idx: got ld %b w_idx %0d, required 1 0", a_ld, a_w_idx);
                end
            end
            if (a_done) done_c = c;
        end
        n_cmp++;
        if (done_c != 53 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL restart_done: got done %0d pending %0d, required 53 0", done_c, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s, c, ndone, nclr, d1, d2;
        push_layer_a(); push_layer_a();
        @(negedge clk); a_start = 1'b1; s = ecnt;
        ndone = 0; nclr = 0; d1 = -1; d2 = -1;
        for (int i = 0; i < 200 && d2 < 0; i++) begin
            @(negedge clk); c = ecnt - s;
            if (a_acc_clr && c <= 53) nclr++;
            if (a_done) begin
                ndone++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 54) begin
                n_cmp++;
                if (a_busy !== 1'b0 || a_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle: got busy %b done %b, required 0 0", a_busy, a_done);
                end
            end
            if (c == 55) begin
                n_cmp++;
                if (a_acc_clr !== 1'b1 || a_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_rerun: got clr %b busy %b, required 1 1", a_acc_clr, a_busy);
                end
                a_start = 1'b0;
            end
        end
        a_start = 1'b0;
        n_cmp++;
        if (d1 != 53 || d2 != 107 || ndone != 2 || nclr != 4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_totals: got done %0d/%0d count %0d clr %0d pending %0d, required 53/107 2 4 0",
                     d1, d2, ndone, nclr, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_small();
        int s, c, clr_c, ld_c, nld, val_c, done_c;
        res_t e;
        exp_b.push_back('{16'd0, 16'd21});
        @(negedge clk); b_start = 1'b1; s = ecnt;
        clr_c = -1; ld_c = -1; nld = 0; val_c = -1; done_c = -1;
        for (int i = 0; i < 30 && done_c < 0; i++) begin
            @(negedge clk); b_start = 1'b0; c = ecnt - s;
            if (b_acc_clr && clr_c < 0) clr_c = c;
            if (b_ld) begin
                nld++; ld_c = c;
                n_cmp++;
                if (b_in_idx !== 16'd0 || b_w_idx !== 16'd0 || b_acc_clr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL small_ld: got in_idx %0d w_idx %0d clr %b, required 0 0 0", b_in_idx, b_w_idx, b_acc_clr);
                end
            end
            if (b_out_valid && val_c < 0) begin
                val_c = c;
                n_cmp++;
                if (exp_b.size() == 0) begin
                    n_bad++;
                    $display("FAIL small_extra: got data %0d, required no result", b_out_data);
                end else begin
                    e = exp_b.pop_front();
                    if (b_out_data !== e.data || b_out_neuron !== e.neuron) begin
                        n_bad++;
                        $display("FAIL small_result: got data %0d neuron %0d, required %0d %0d",
                                 b_out_data, b_out_neuron, e.data, e.neuron);
                    end
                end
            end
            if (b_done) done_c = c;
        end
        n_cmp++;
        if (clr_c != 1 || ld_c != 2 || nld != 1 || val_c != 6 || done_c != 7) begin
            n_bad++;
            $display("FAIL small_timing: got clr %0d ld %0d x%0d valid %0d done %0d, required 1 2 x1 6 7",
                     clr_c, ld_c, nld, val_c, done_c);
        end
        @(negedge clk);
        n_cmp++;
        if (b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL small_idle: got busy %b, required 0", b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
